// File: rtl/detectfaces_mul_arbiter_if.sv
// detectfaces_mul_arbiter_if
//   Request/response bundle for the shared 16x5 multiplier arbiter.
//   master : requester/consumer side (drives req_valid, req_din0, req_din1, rsp_ready)
//   slave  : arbiter side (drives req_ready, rsp_valid, rsp_dout, rsp_id, busy)
//   req_din0/req_din1 pack requester i at [i*WIDTH +: WIDTH].
interface detectfaces_mul_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 5,
    parameter int DOUT_WIDTH = 20
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DOUT_WIDTH-1:0]         rsp_dout;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic                          busy;

    modport master (
        output req_valid, req_din0, req_din1, rsp_ready,
        input  req_ready, rsp_valid, rsp_dout, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_din0, req_din1, rsp_ready,
        output req_ready, rsp_valid, rsp_dout, rsp_id, busy
    );
endinterface

// File: rtl/detectfaces_mul_arbiter.sv
// detectfaces_mul_arbiter
//   Shares one unsigned DIN0_WIDTH x DIN1_WIDTH multiplier among NUM_REQ
//   requesters using round-robin arbitration and valid/ready handshakes.
//   One registered response slot, tagged with the requester index.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : detectfaces_mul_arbiter_if.slave (request ports, response channel, busy)
// Build option:
//   DETECTFACES_MUL_ARB_SAT_EN defined   -> products above 2^DOUT_WIDTH-1 saturate to all ones
//   DETECTFACES_MUL_ARB_SAT_EN undefined -> product truncated to low DOUT_WIDTH bits
module detectfaces_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 5,
    parameter int DOUT_WIDTH = 20
) (
    input logic                     ap_clk,
    input logic                     ap_rst,
    detectfaces_mul_arbiter_if.slave bus
);
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   gnt;
    logic                  found;
    logic                  slot_free;
    logic                  xfer;
    logic                  rsp_valid_q;
    logic [DOUT_WIDTH-1:0] rsp_dout_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DIN0_WIDTH-1:0] sel_a;
    logic [DIN1_WIDTH-1:0] sel_b;
    logic [PROD_WIDTH-1:0] prod;
    logic [DOUT_WIDTH-1:0] prod_fit;

    assign slot_free = !rsp_valid_q || bus.rsp_ready;
    assign xfer      = found && slot_free && !ap_rst;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        int unsigned         idx;
        logic [ID_WIDTH-1:0] cand;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_WIDTH'(idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt == ID_WIDTH'(i)) begin
                sel_a = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                sel_b = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    assign prod = PROD_WIDTH'(sel_a) * PROD_WIDTH'(sel_b);

`ifdef DETECTFACES_MUL_ARB_SAT_EN
    // One guard bit above both widths so the overflow test is valid for any width mix.
    localparam int EXT_WIDTH = ((PROD_WIDTH > DOUT_WIDTH) ? PROD_WIDTH : DOUT_WIDTH) + 1;
    logic [EXT_WIDTH-1:0] prod_ext;
    assign prod_ext = EXT_WIDTH'(prod);
    assign prod_fit = ((prod_ext >> DOUT_WIDTH) != '0) ? '1 : DOUT_WIDTH'(prod_ext);
`else
    assign prod_fit = DOUT_WIDTH'(prod);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_dout_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            // A drain in the same cycle is covered here: new data replaces old, no bubble.
            rsp_valid_q <= 1'b1;
            rsp_dout_q  <= prod_fit;
            rsp_id_q    <= gnt;
            if (gnt == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt + 1'b1;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = rsp_valid_q;
endmodule

// File: doc/detectfaces_mul_arbiter.md
Name: detectfaces_mul_arbiter

Overview:
- Shares one unsigned 16x5->20 multiplier among NUM_REQ requesters in the detectFaces datapath, e.g. several scaling/index computations contending for one DSP.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Single registered response channel, tagged with the requester index, with backpressure.
- Replaces per-caller multiplier instances when DSP budget is tight.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 2..8).
- DIN0_WIDTH, 16, unsigned operand A width.
- DIN1_WIDTH, 5, unsigned operand B width.
- DOUT_WIDTH, 20, result width; the product is truncated or saturated to this width.
- ID_WIDTH, derived localparam = clog2(NUM_REQ), minimum 1.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_din0  in  NUM_REQ*DIN0_WIDTH  operand A; requester i occupies slice [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_din1  in  NUM_REQ*DIN1_WIDTH  operand B, packed the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_dout  out  DOUT_WIDTH  product.
- rsp_id  out  ID_WIDTH  index of the requester that produced rsp_dout.
- busy  out  1  equals rsp_valid; used for ap_idle composition.

Behaviour:
- Clock/reset: one clock, ap_clk. Reset is ap_rst, synchronous and active-high.
- Reset values: rsp_valid=0, rsp_dout=0, rsp_id=0, busy=0, rr pointer=0 (requester 0 highest priority). req_ready is forced to 0 while ap_rst=1.
- Output slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational): when slot_free, grant the first i with req_valid[i]=1, searching from pointer upward with wrap modulo NUM_REQ. req_ready = one-hot(grant) when slot_free, else 0. No request is accepted while the slot is full and not draining.
- Handshake rules:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - Requesters must hold valid and operands stable until transfer.
  - req_valid must not depend on req_ready.
  - req_ready may depend on req_valid (single-cycle combinational path).
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod NUM_REQ. With no transfer, the pointer holds.
- Datapath: on a transfer, the unsigned product of the two operands (full width DIN0_WIDTH+DIN1_WIDTH) is computed combinationally. rsp_dout <= low DOUT_WIDTH bits, rsp_id <= g, rsp_valid <= 1.
- Latency: exactly 1 cycle from transfer edge to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- Drain: if rsp_valid && rsp_ready and there is no new transfer, rsp_valid <= 0. A drain and a new transfer in the same cycle keep rsp_valid=1 with the new data (no bubble).
- Stall: while rsp_valid && !rsp_ready, rsp_dout and rsp_id hold stable and no request is granted.
- Fairness: a continuously asserting requester is granted within NUM_REQ accepted transfers.
- Reset mid-operation: an in-flight or stalled result is discarded with no output handshake, and the pointer returns to 0.
- Zero operands yield 0. No other arithmetic exceptions exist.

Optional Feature:
- Macro: DETECTFACES_MUL_ARB_SAT_EN.
- Defined: if the full-width product exceeds 2^DOUT_WIDTH-1, rsp_dout = all ones (0xFFFFF at defaults); otherwise the exact product.
- Undefined: plain truncation to the low DOUT_WIDTH bits, matching HLS-generated multiplier semantics.
- Latency and handshakes are identical in both builds.

Test Plan:
- Reset: assert ap_rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_dout=0 throughout. First grant after release goes to requester 0.
- Single request: req0 A=1000, B=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_dout=7000, rsp_id=0. rsp_valid drops the following cycle.
- Round robin: all 4 requesters hold valid with A=i+1, B=3 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 back to back; rsp_dout = 3,6,9,12 repeating.
- Backpressure: rsp_ready=0 for 3 cycles after the first result -> rsp_dout/rsp_id frozen, req_ready=0. On release, results continue with no loss or duplication, and the next grant is in pointer order.
- Overflow: A=0xFFFF, B=31 (product 0x1EFFE1) -> rsp_dout=0xEFFE1 without the macro; 0xFFFFF with DETECTFACES_MUL_ARB_SAT_EN. A=0x8000, B=31 -> 0xF8000 in both builds.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, pulse ap_rst 1 cycle -> rsp_valid=0 the next cycle. Pending requesters are then served starting from requester 0.
